// File: rtl/piton_l15_emu.sv
// L1.5 emulator: wake-up interrupt, in-order request FIFO, fixed-latency responder, word memory.
// Define L15_EMU_RANDLAT_EN to add 0-7 LFSR-driven extra cycles to every response latency.
module piton_l15_emu #(
  parameter int MEM_WORDS    = 1024,
  parameter int REQ_DEPTH    = 2,
  parameter int RESP_LATENCY = 4,
  parameter int WAKE_DELAY   = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [4:0]  transducer_l15_rqtype,
  input  logic [2:0]  transducer_l15_size,
  input  logic [31:0] transducer_l15_address,
  input  logic [31:0] transducer_l15_data,
  input  logic        transducer_l15_val,
  output logic        l15_transducer_ack,
  output logic        l15_transducer_header_ack,
  output logic        l15_transducer_val,
  output logic [63:0] l15_transducer_data_0,
  output logic [63:0] l15_transducer_data_1,
  output logic [31:0] l15_transducer_returntype,
  input  logic        transducer_l15_req_ack
);
  localparam logic [4:0] RQ_IFILL = 5'b10000;
  localparam logic [4:0] RQ_LOAD  = 5'b00000;
  localparam logic [4:0] RQ_STORE = 5'b00001;
  localparam logic [3:0] RT_IFILL = 4'b0001;
  localparam logic [3:0] RT_LOAD  = 4'b0000;
  localparam logic [3:0] RT_ST    = 4'b0100;
  localparam logic [3:0] RT_INT   = 4'b0111;
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int OCC_W = $clog2(REQ_DEPTH + 1);
  localparam int CNT_MAX = (WAKE_DELAY > RESP_LATENCY + 8) ? WAKE_DELAY : RESP_LATENCY + 8;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  typedef struct packed {
    logic [4:0]  rqtype;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  typedef enum logic [2:0] {WAKE_WAIT, WAKE_SEND, IDLE, LAT, RESP} state_t;

  state_t            state, state_nxt;
  req_t              fifo [REQ_DEPTH];
  req_t              head;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [OCC_W-1:0]  occ, occ_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, lat;
  logic [31:0]       mem [MEM_WORDS];
  logic [3:0]        rtype_q, rtype_n;
  logic [63:0]       d0_q, d1_q, d0_n, d1_n;
  logic              hdr_ack_q, push, pop, load_resp, head_known, woken_nxt;
  logic [IDX_W-1:0]  idx, blk0, blk1, blk2, blk3;
  logic [3:0]        be;
  logic [31:0]       wdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(REQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef L15_EMU_RANDLAT_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (!nrst) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign lat = CNT_W'(RESP_LATENCY) + CNT_W'(lfsr[2:0]);
`else
  assign lat = CNT_W'(RESP_LATENCY);
`endif

  assign head       = fifo[rd_ptr];
  assign head_known = (head.rqtype == RQ_IFILL) || (head.rqtype == RQ_LOAD) ||
                      (head.rqtype == RQ_STORE);
  assign push       = transducer_l15_val & hdr_ack_q;
  assign l15_transducer_ack        = push;
  assign l15_transducer_header_ack = hdr_ack_q;

  // Next state. Entering RESP always comes from IDLE or LAT, so a store popped
  // from RESP has landed in memory before the next response is sampled.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    load_resp = 1'b0;
    case (state)
      WAKE_WAIT: begin
        if (cnt == CNT_W'(WAKE_DELAY - 1)) begin
          state_nxt = WAKE_SEND;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAKE_SEND: if (transducer_l15_req_ack) state_nxt = IDLE;
      IDLE: begin
        if (occ != '0) begin
          if (!head_known) begin
            pop = 1'b1;
          end else if (lat == CNT_W'(1)) begin
            load_resp = 1'b1;
            state_nxt = RESP;
          end else begin
            cnt_nxt   = lat - CNT_W'(2);
            state_nxt = LAT;
          end
        end
      end
      LAT: begin
        if (cnt == '0) begin
          if (head_known) begin
            load_resp = 1'b1;
            state_nxt = RESP;
          end else begin
            pop       = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESP: begin
        if (transducer_l15_req_ack) begin
          pop = 1'b1;
          if (occ > OCC_W'(1)) begin
            cnt_nxt   = lat - CNT_W'(1);
            state_nxt = LAT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = WAKE_WAIT;
    endcase
  end

  assign occ_nxt   = occ + OCC_W'(push) - OCC_W'(pop);
  assign woken_nxt = (state_nxt == IDLE) || (state_nxt == LAT) || (state_nxt == RESP);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= WAKE_WAIT;
      cnt       <= '0;
      occ       <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      hdr_ack_q <= 1'b0;
      rtype_q   <= '0;
      d0_q      <= '0;
      d1_q      <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      occ       <= occ_nxt;
      hdr_ack_q <= woken_nxt && (occ_nxt != OCC_W'(REQ_DEPTH));
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (load_resp) begin
        rtype_q <= rtype_n;
        d0_q    <= d0_n;
        d1_q    <= d1_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo[wr_ptr] <= '{rqtype: transducer_l15_rqtype, size: transducer_l15_size,
                         addr: transducer_l15_address, data: transducer_l15_data};
  end

  assign idx  = head.addr[IDX_W+1:2];
  assign blk0 = {head.addr[IDX_W+1:4], 2'b00};
  assign blk1 = {head.addr[IDX_W+1:4], 2'b01};
  assign blk2 = {head.addr[IDX_W+1:4], 2'b10};
  assign blk3 = {head.addr[IDX_W+1:4], 2'b11};

  always_comb begin
    rtype_n = RT_LOAD;
    d0_n    = '0;
    d1_n    = '0;
    case (head.rqtype)
      RQ_IFILL: begin
        rtype_n = RT_IFILL;
        d0_n    = {mem[blk1], mem[blk0]};
        d1_n    = {mem[blk3], mem[blk2]};
      end
      RQ_LOAD:  d0_n = {mem[idx], mem[idx]};
      RQ_STORE: rtype_n = RT_ST;
      default:  ;
    endcase
  end

  // Sub-word stores replicate the right-aligned data across lanes; enables pick the lane.
  always_comb begin
    case (head.size)
      3'd0: begin
        be    = 4'b0001 << head.addr[1:0];
        wdata = {4{head.data[7:0]}};
      end
      3'd1: begin
        be    = head.addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{head.data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = head.data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst && pop && head.rqtype == RQ_STORE)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
  end

  always_comb begin
    l15_transducer_val        = 1'b0;
    l15_transducer_returntype = '0;
    l15_transducer_data_0     = '0;
    l15_transducer_data_1     = '0;
    if (state == WAKE_SEND) begin
      l15_transducer_val        = 1'b1;
      l15_transducer_returntype = {28'b0, RT_INT};
    end else if (state == RESP) begin
      l15_transducer_val        = 1'b1;
      l15_transducer_returntype = {28'b0, rtype_q};
      l15_transducer_data_0     = d0_q;
      l15_transducer_data_1     = d1_q;
    end
  end
endmodule

// File: tb/tb_piton_l15_emu.sv
// Directed bench for piton_l15_emu: wake-up, vector table of fills/loads/stores, back-pressure, reset.
module tb_piton_l15_emu;
  logic        clk = 1'b0;
  logic        nrst;
  logic [4:0]  rqtype;
  logic [2:0]  size;
  logic [31:0] address, wdata;
  logic        req_val, req_ack;
  logic        ack, header_ack, resp_val;
  logic [63:0] data_0, data_1;
  logic [31:0] returntype;

  int passed = 0;
  int total  = 0;

  piton_l15_emu dut (
    .clk(clk), .nrst(nrst),
    .transducer_l15_rqtype(rqtype), .transducer_l15_size(size),
    .transducer_l15_address(address), .transducer_l15_data(wdata),
    .transducer_l15_val(req_val),
    .l15_transducer_ack(ack), .l15_transducer_header_ack(header_ack),
    .l15_transducer_val(resp_val),
    .l15_transducer_data_0(data_0), .l15_transducer_data_1(data_1),
    .l15_transducer_returntype(returntype),
    .transducer_l15_req_ack(req_ack)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] IFILL = 5'b10000, LOAD = 5'b00000, STORE = 5'b00001;

  typedef struct {
    logic [4:0]  rq;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  rt;
    logic [63:0] d0;
    logic [63:0] d1;
  } vec_t;

  vec_t vt [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passed++;
  endtask

  task automatic send(input logic [4:0] rq, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] d);
    int w;
    w = 0;
    while (!header_ack && w < 50) begin
      tick();
      w++;
    end
    check("header_ack_ready", header_ack, 1);
    rqtype = rq; size = sz; address = a; wdata = d; req_val = 1'b1;
    #1;
    check("ack_on_accept", ack, 1);
    tick();
    req_val = 1'b0;
  endtask

  task automatic wait_val(output int n);
    n = 0;
    while (!resp_val && n < 64) begin
      tick();
      n++;
    end
    if (!resp_val) check("response_timeout", 0, 1);
  endtask

  task automatic consume();
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    check("val_drop_after_req_ack", resp_val, 0);
  endtask

  task automatic wake_sequence(input string tag);
    req_ack = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      check({tag, "_wait"}, {resp_val, header_ack}, 2'b00);
    end
    tick();
    check({tag, "_int_val"}, {resp_val, header_ack}, 2'b10);
    check({tag, "_int_type"}, returntype, 32'd7);
    check({tag, "_int_data"}, data_0 | data_1, 0);
    tick();
    check({tag, "_after"}, {resp_val, header_ack}, 2'b01);
    req_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vt[0]  = '{STORE, 3'd2, 32'h0,    32'h00500A13, 4'd4, 64'h0, 64'h0};
    vt[1]  = '{STORE, 3'd2, 32'h4,    32'h001080B3, 4'd4, 64'h0, 64'h0};
    vt[2]  = '{STORE, 3'd2, 32'h8,    32'h00202023, 4'd4, 64'h0, 64'h0};
    vt[3]  = '{STORE, 3'd2, 32'hC,    32'h00002A83, 4'd4, 64'h0, 64'h0};
    vt[4]  = '{IFILL, 3'd0, 32'h0,    32'h0, 4'd1, 64'h001080B3_00500A13, 64'h00002A83_00202023};
    vt[5]  = '{IFILL, 3'd3, 32'hB,    32'h0, 4'd1, 64'h001080B3_00500A13, 64'h00002A83_00202023};
    vt[6]  = '{STORE, 3'd2, 32'h40,   32'hDEADBEEF, 4'd4, 64'h0, 64'h0};
    vt[7]  = '{LOAD,  3'd2, 32'h40,   32'h0, 4'd0, 64'hDEADBEEF_DEADBEEF, 64'h0};
    vt[8]  = '{STORE, 3'd0, 32'h41,   32'h00000055, 4'd4, 64'h0, 64'h0};
    vt[9]  = '{LOAD,  3'd2, 32'h40,   32'h0, 4'd0, 64'hDEAD55EF_DEAD55EF, 64'h0};
    vt[10] = '{STORE, 3'd1, 32'h43,   32'h00001234, 4'd4, 64'h0, 64'h0};
    vt[11] = '{LOAD,  3'd2, 32'h1042, 32'h0, 4'd0, 64'h123455EF_123455EF, 64'h0};
    vt[12] = '{STORE, 3'd2, 32'h44,   32'hCAFEF00D, 4'd4, 64'h0, 64'h0};
    vt[13] = '{STORE, 3'd0, 32'h47,   32'h000000AB, 4'd4, 64'h0, 64'h0};

    nrst = 1'b0; req_val = 1'b0; req_ack = 1'b1;
    rqtype = '0; size = '0; address = '0; wdata = '0;
    repeat (3) tick();
    check("reset_ctrl", {resp_val, header_ack, ack}, 3'b000);
    check("reset_type", returntype, 0);
    check("reset_data", data_0 | data_1, 0);
    nrst = 1'b1;
    wake_sequence("wake");

    for (int i = 0; i < 14; i++) begin
      send(vt[i].rq, vt[i].sz, vt[i].addr, vt[i].data);
      wait_val(n);
      check($sformatf("v%0d_latency", i), n, 4);
      check($sformatf("v%0d_type", i), returntype, {28'b0, vt[i].rt});
      check($sformatf("v%0d_data0", i), data_0, vt[i].d0);
      check($sformatf("v%0d_data1", i), data_1, vt[i].d1);
      consume();
    end

    send(LOAD, 3'd2, 32'h44, 0);
    wait_val(n);
    check("lane3_byte_load", data_0, 64'hABFEF00D_ABFEF00D);
    consume();

    // Store then load queued back to back: the load sees the store.
    send(STORE, 3'd2, 32'h80, 32'h0BADF00D);
    send(LOAD, 3'd2, 32'h80, 0);
    wait_val(n);
    check("b2b_st_type", returntype, 4);
    consume();
    wait_val(n);
    check("b2b_ld_latency", n, 4);
    check("b2b_ld_type", returntype, 0);
    check("b2b_ld_data", data_0, 64'h0BADF00D_0BADF00D);
    consume();

    // Unknown request type is accepted and silently dropped.
    send(5'b00010, 3'd2, 32'h80, 0);
    send(LOAD, 3'd2, 32'h80, 0);
    wait_val(n);
    check("unk_then_load_latency", n, 4);
    check("unk_then_load_type", returntype, 0);
    check("unk_then_load_data", data_0, 64'h0BADF00D_0BADF00D);
    consume();
    repeat (6) tick();
    check("unk_no_extra_resp", resp_val, 0);

    // Back-pressure: two entries fill the FIFO, third request waits.
    send(LOAD, 3'd2, 32'h0, 0);
    send(LOAD, 3'd2, 32'h4, 0);
    check("full_header_ack", header_ack, 0);
    rqtype = LOAD; size = 3'd2; address = 32'h40; wdata = 0; req_val = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      check("full_no_ack", ack, 0);
      tick();
    end
    check("held_val", resp_val, 1);
    check("held_first_data", data_0, 64'h00500A13_00500A13);
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    check("third_ack_after_pop", ack, 1);
    tick();
    req_val = 1'b0;
    wait_val(n);
    check("second_data", data_0, 64'h001080B3_001080B3);
    consume();
    wait_val(n);
    check("third_data", data_0, 64'h123455EF_123455EF);
    consume();

    // Reset during a response drops it and re-runs the wake-up.
    send(LOAD, 3'd2, 32'h4, 0);
    wait_val(n);
    check("pre_reset_val", resp_val, 1);
    nrst = 1'b0;
    tick();
    check("mid_reset_ctrl", {resp_val, header_ack}, 2'b00);
    check("mid_reset_out", data_0 | data_1 | 64'(returntype), 0);
    nrst = 1'b1;
    wake_sequence("rewake");
    repeat (8) tick();
    check("fifo_empty_after_reset", resp_val, 0);
    send(LOAD, 3'd2, 32'h80, 0);
    wait_val(n);
    check("mem_kept_80", data_0, 64'h0BADF00D_0BADF00D);
    consume();
    send(LOAD, 3'd2, 32'h40, 0);
    wait_val(n);
    check("mem_kept_40", data_0, 64'h123455EF_123455EF);
    consume();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
